// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S source arbiter slice.
// No logic; state encoding and parameter defaults only.
// Imported by the interface, the gain stage and the arbiter top.
package i2s_pkg;

  localparam int NUM_SRC_DEF   = 3;
  localparam int DATA_BITS_DEF = 24;
  localparam int FADE_LOG2_DEF = 6;

  // Arbiter FSM states: silent, ramping up, at unity, ramping down
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_PLAY     = 2'd2,
    ST_FADE_OUT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i2s_src_arbiter_if.sv
// Bundle of source requests/samples in and arbitrated sample/status out.
// Pure wiring; no latency of its own.
// No backpressure: samples are held levels, consumed once per frame.
interface i2s_src_arbiter_if #(
  parameter int NUM_SRC   = i2s_pkg::NUM_SRC_DEF,
  parameter int DATA_BITS = i2s_pkg::DATA_BITS_DEF,
  parameter int FADE_LOG2 = i2s_pkg::FADE_LOG2_DEF
);
  logic                           lrclk;
  logic [NUM_SRC-1:0]             req;
  logic [NUM_SRC*DATA_BITS-1:0]   src_data;
  logic                           mute;
  logic signed [DATA_BITS-1:0]    out_sample;
  logic [NUM_SRC-1:0]             grant;
  logic                           busy;
  logic [FADE_LOG2:0]             gain;

  // Source side: drives requests, samples, mute and word select
  modport master (
    output lrclk, req, src_data, mute,
    input  out_sample, grant, busy, gain
  );

  // Arbiter side
  modport slave (
    input  lrclk, req, src_data, mute,
    output out_sample, grant, busy, gain
  );
endinterface

// File: rtl/i2s_fade_gain.sv
// Scales a signed sample by gain/2**FADE_LOG2 (floor), registered output.
// Latency: 1 clk_25m cycle from sample_i/gain_i to sample_o.
// No backpressure: recomputed every cycle.
module i2s_fade_gain #(
  parameter int DATA_BITS = i2s_pkg::DATA_BITS_DEF,
  parameter int FADE_LOG2 = i2s_pkg::FADE_LOG2_DEF
) (
  input  logic                        clk_25m,
  input  logic                        rst_n,
  input  logic signed [DATA_BITS-1:0] sample_i,
  input  logic [FADE_LOG2:0]          gain_i,
  output logic signed [DATA_BITS-1:0] sample_o
);
  // Product holds sample * (2**FADE_LOG2) plus a sign bit of headroom
  localparam int PW = DATA_BITS + FADE_LOG2 + 2;

  logic signed [PW-1:0] prod;
  logic signed [DATA_BITS-1:0] sample_q;

  // Full-width signed product; gain is treated as a non-negative value
  always_comb begin
    prod = PW'(sample_i) * PW'($signed({1'b0, gain_i}));
  end

  // Arithmetic shift floors toward -inf, then truncate to sample width
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) sample_q <= '0;
    else        sample_q <= DATA_BITS'(prod >>> FADE_LOG2);
  end

  assign sample_o = sample_q;
endmodule

// File: rtl/i2s_src_arbiter.sv
// Fixed-priority source select for i2s_tx, switching with a gain ramp at frame starts.
// Latency: state/grant/gain change on the lrclk-fall tick; out_sample 1 cycle later.
// No backpressure: one decision per frame, sources present held samples.
module i2s_src_arbiter
  import i2s_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int FADE_LOG2 = FADE_LOG2_DEF
) (
  input logic               clk_25m,
  input logic               rst_n,
  i2s_src_arbiter_if.slave  bus
);
  localparam logic [FADE_LOG2:0] GAIN_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};
  localparam logic [FADE_LOG2:0] GAIN_FULL = {1'b1, {FADE_LOG2{1'b0}}};

  arb_state_t                  state_q;
  logic [NUM_SRC-1:0]          grant_q;
  logic [FADE_LOG2:0]          gain_q;
  logic                        lrclk_q;   // lrclk delayed one cycle
  logic                        tick;
  logic [NUM_SRC-1:0]          win_oh;
  logic                        win_vld;
  logic signed [DATA_BITS-1:0] sel_data;
  logic signed [DATA_BITS-1:0] out_sample;

  // Left-slot start: lrclk falling edge
  assign tick = lrclk_q & ~bus.lrclk;

  // Lowest-index requester wins; mute suppresses every request
  always_comb begin
    win_oh  = '0;
    win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.req[i] && !bus.mute) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_vld   = 1'b1;
      end
    end
  end

  // Owner's held sample; zero when nobody owns the path
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) sel_data = bus.src_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Ownership/ramp FSM; advances only on frame ticks, fades always end at 0 before a handover
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gain_q  <= '0;
      lrclk_q <= 1'b1;
    end else begin
      lrclk_q <= bus.lrclk;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (win_vld) begin
              grant_q <= win_oh;
              gain_q  <= GAIN_ONE;
              state_q <= ST_FADE_IN;
            end
          end
          ST_FADE_IN: begin
            // Gain is held on the abort tick so the fade-out starts where the ramp stood
            if (win_oh != grant_q) begin
              state_q <= ST_FADE_OUT;
            end else begin
              gain_q <= gain_q + GAIN_ONE;
              if (gain_q + GAIN_ONE == GAIN_FULL) state_q <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (win_oh != grant_q) begin
              gain_q  <= gain_q - GAIN_ONE;
              state_q <= ST_FADE_OUT;
            end
          end
          ST_FADE_OUT: begin
            if (gain_q != '0) begin
              gain_q <= gain_q - GAIN_ONE;
            end else if (win_vld) begin
              grant_q <= win_oh;
              gain_q  <= GAIN_ONE;
              state_q <= ST_FADE_IN;
            end else begin
              grant_q <= '0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  i2s_fade_gain #(
    .DATA_BITS (DATA_BITS),
    .FADE_LOG2 (FADE_LOG2)
  ) u_fade_gain (
    .clk_25m  (clk_25m),
    .rst_n    (rst_n),
    .sample_i (sel_data),
    .gain_i   (gain_q),
    .sample_o (out_sample)
  );

  assign bus.out_sample = out_sample;
  assign bus.grant      = grant_q;
  assign bus.gain       = gain_q;
  assign bus.busy       = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);
endmodule

// File: tb/tb_i2s_src_arbiter.sv
// Directed and randomized frame-level stimulus against an integer reference model.
// Each frame: lrclk low/high, check after the tick plus one cycle.
// Inputs change only while lrclk is high, away from the tick.
`timescale 1ns/1ps
module tb_i2s_src_arbiter;
  localparam int NS = 3;
  localparam int DB = 24;
  localparam int FL = 2;
  localparam int FULL = 1 << FL;

  // Model phases (independent of the RTL encoding)
  localparam int P_IDLE = 0, P_UP = 1, P_FULL = 2, P_DOWN = 3;

  logic clk_25m = 1'b0;
  logic rst_n   = 1'b0;

  i2s_src_arbiter_if #(.NUM_SRC(NS), .DATA_BITS(DB), .FADE_LOG2(FL)) bus ();

  i2s_src_arbiter #(.NUM_SRC(NS), .DATA_BITS(DB), .FADE_LOG2(FL)) dut (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #20 clk_25m = ~clk_25m;

  int errors = 0;
  int checks = 0;

  longint src_val [NS];
  int m_phase, m_owner, m_gain;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input longint v);
    logic [DB-1:0] w;
    src_val[i] = v;
    w = DB'(v);
    bus.src_data[i*DB +: DB] = w;
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_winner();
    if (bus.mute) return -1;
    for (int i = 0; i < NS; i++) if (bus.req[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_owner = -1;
    m_gain  = 0;
  endtask

  // One frame decision made from the rules: ramp toward the winner, never jump
  task automatic model_tick();
    int w;
    w = model_winner();
    case (m_phase)
      P_IDLE: if (w >= 0) begin m_owner = w; m_gain = 1; m_phase = P_UP; end
      P_UP: begin
        if (w != m_owner) m_phase = P_DOWN;
        else begin
          m_gain++;
          if (m_gain == FULL) m_phase = P_FULL;
        end
      end
      P_FULL: if (w != m_owner) begin m_gain--; m_phase = P_DOWN; end
      default: begin
        if (m_gain > 0) m_gain--;
        else if (w >= 0) begin m_owner = w; m_gain = 1; m_phase = P_UP; end
        else begin m_owner = -1; m_phase = P_IDLE; end
      end
    endcase
  endtask

  function automatic longint model_out();
    if (m_owner < 0) return 0;
    return floor_div(src_val[m_owner] * m_gain, FULL);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_grant"}, bus.grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk({tag, "_gain"}, bus.gain, m_gain);
    chk({tag, "_busy"}, bus.busy, (m_phase == P_UP || m_phase == P_DOWN) ? 1 : 0);
    chk({tag, "_out"}, $signed(bus.out_sample), model_out());
  endtask

  task automatic frame(input string tag);
    @(negedge clk_25m) bus.lrclk = 1'b0;
    @(posedge clk_25m) model_tick();
    @(posedge clk_25m);
    @(negedge clk_25m) check_all(tag);
    repeat (2) @(negedge clk_25m);
    bus.lrclk = 1'b1;
    repeat (4) @(negedge clk_25m);
  endtask

  initial begin
    bus.lrclk = 1'b1;
    bus.req = '0;
    bus.mute = 1'b0;
    bus.src_data = '0;
    for (int i = 0; i < NS; i++) set_src(i, 0);
    model_reset();
    repeat (3) @(negedge clk_25m);
    check_all("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_25m);

    // 1: fade in src0 from silence
    set_src(0, 4000);
    bus.req = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      frame("t1");
      chk("t1_out_ramp", $signed(bus.out_sample), 1000 * k);
    end
    frame("t1_play");
    chk("t1_busy", bus.busy, 0);
    chk("t1_grant", bus.grant, 1);

    // 2: move to src1, then preempt it with src0
    set_src(1, -4000);
    bus.req = 3'b010;
    for (int k = 0; k < 9; k++) frame("t2_move");
    chk("t2_grant1", bus.grant, 2);
    bus.req = 3'b011;
    for (int k = 1; k <= 4; k++) begin
      frame("t2_down");
      chk("t2_out_down", $signed(bus.out_sample), -4000 + 1000 * k);
    end
    for (int k = 1; k <= 4; k++) begin
      frame("t2_up");
      chk("t2_out_up", $signed(bus.out_sample), 1000 * k);
      chk("t2_grant0", bus.grant, 1);
    end

    // 3: preempt a fade-in of src2 at gain 2
    set_src(2, 8000);
    bus.req = 3'b100;
    for (int k = 0; k < 6; k++) frame("t3_pre");
    chk("t3_gain2", bus.gain, 2);
    bus.req = 3'b101;
    for (int k = 0; k < 3; k++) begin
      frame("t3_abort");
      chk("t3_gain_abort", bus.gain, 2 - k);
      chk("t3_grant_abort", bus.grant, 4);
    end
    frame("t3_switch");
    chk("t3_grant_new", bus.grant, 1);
    chk("t3_gain_new", bus.gain, 1);
    for (int k = 0; k < 3; k++) frame("t3_fill");
    chk("t3_play_busy", bus.busy, 0);

    // 4: mute fades out to idle, release fades back in on src0
    bus.mute = 1'b1;
    for (int k = 0; k < 5; k++) frame("t4_mute");
    chk("t4_grant_idle", bus.grant, 0);
    chk("t4_out_idle", $signed(bus.out_sample), 0);
    bus.mute = 1'b0;
    for (int k = 0; k < 4; k++) frame("t4_unmute");
    chk("t4_grant_back", bus.grant, 1);
    chk("t4_gain_back", bus.gain, FULL);

    // 5: floor rounding of small samples
    bus.mute = 1'b1;
    for (int k = 0; k < 5; k++) frame("t5_idle");
    set_src(0, -3);
    bus.mute = 1'b0;
    frame("t5_neg");
    chk("t5_neg_floor", $signed(bus.out_sample), -1);
    set_src(0, 3);
    repeat (2) @(negedge clk_25m);
    chk("t5_pos_floor", $signed(bus.out_sample), 0);
    check_all("t5_pos");

    // 6: asynchronous reset mid-fade
    frame("t6_g2");
    frame("t6_g3");
    chk("t6_gain3", bus.gain, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_rst");
    @(negedge clk_25m) rst_n = 1'b1;
    repeat (2) @(negedge clk_25m);
    frame("t6_after");
    chk("t6_gain1", bus.gain, 1);
    chk("t6_busy", bus.busy, 1);

    // Randomized frames
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 3) bus.req = 3'($urandom_range(0, 7));
      bus.mute = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) begin
        logic [DB-1:0] r;
        int s;
        r = DB'($urandom);
        s = $urandom_range(0, NS - 1);
        set_src(s, longint'($signed(r)));
      end
      frame("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2s_src_arbiter.md
Name: i2s_src_arbiter

Overview:
Shares the I2S transmit sample path between NUM_SRC parallel audio sources, e.g. mic loopback, test tone and FFT playback. It picks one source by fixed priority, switches only at frame boundaries, and ramps the gain down and up on every switch so the amp never sees a step discontinuity. It sits between the per-source sample registers and the i2s_tx left_data input, and runs in the clk_25m domain alongside i2s_clkgen.

Parameters:
NUM_SRC, 3, number of requesting sources; index 0 has the highest priority.
DATA_BITS, 24, signed sample width.
FADE_LOG2, 6, the ramp has 2**FADE_LOG2 frames (64 frames, about 1.3 ms at 48.8 kHz).

Ports:
clk_25m  in  1  system clock, 25 MHz
rst_n  in  1  reset, asynchronous, active-low
lrclk  in  1  word select from i2s_clkgen, synchronous to clk_25m (no synchroniser)
req  in  NUM_SRC  level request per source
src_data  in  NUM_SRC*DATA_BITS  held signed sample per source; source i occupies bits [i*DATA_BITS +: DATA_BITS]
mute  in  1  level; forces fade-out and holds silence
out_sample  out  DATA_BITS  signed sample to i2s_tx left_data
grant  out  NUM_SRC  one-hot current owner; all zero when none
busy  out  1  high in FADE_IN or FADE_OUT
gain  out  FADE_LOG2+1  current gain step, 0..2**FADE_LOG2

Behaviour:
- Reset values: out_sample=0, grant=0, busy=0, gain=0, state=IDLE, lrclk_d=1.
- Frame tick: a 1-cycle pulse when lrclk_d=1 and lrclk=0 (lrclk falling edge = left-slot start).
  - All state, grant and gain updates happen only on tick cycles.
- Winner: the lowest index i with req[i]=1 and mute=0; "none" if no such i.
- States (encoded in i2s_pkg): IDLE, FADE_IN, PLAY, FADE_OUT.
- IDLE, on tick:
  - winner exists -> grant=winner, gain=1, go to FADE_IN.
  - otherwise stay in IDLE.
- FADE_IN, on tick:
  - winner differs from grant (includes none) -> go to FADE_OUT; gain is held this tick.
  - else gain+1; when gain reaches 2**FADE_LOG2 -> go to PLAY.
- PLAY, on tick:
  - winner differs from grant -> FADE_OUT, gain-1.
- FADE_OUT, on tick:
  - gain>0 -> gain-1.
  - gain==0 and winner exists -> grant=winner, gain=1, go to FADE_IN.
  - gain==0 and no winner -> grant=0, go to IDLE.
- Fade-out always starts from the current gain. There is no jump to full scale and no restart at zero.
- Priority preemption: a higher-priority request during PLAY or FADE_IN causes a fade-out of the current owner, then a fade-in of the new one.
- Owner drops req mid-fade: the fade continues on the owner's held src_data until gain reaches 0.
- Datapath (registered): out_sample = (src_data[grant] * gain) >>> FADE_LOG2.
  - Full-width signed product; arithmetic right shift (floor); truncate to DATA_BITS.
  - gain = 2**FADE_LOG2 is exact unity; gain 0 or grant 0 gives 0.
  - out_sample updates every clk cycle, so its latency is 1 cycle from grant/gain/src_data changes. It is stable for the rest of the frame once src_data is stable.
- busy is combinational from state.
- An asynchronous reset mid-fade returns everything to the reset values immediately; out_sample=0 the next cycle onward.

Decomposition:
- i2s_pkg: state encoding localparams, DATA_BITS default, FADE_LOG2 default.
- Sub-module i2s_fade_gain: signed multiply-by-gain and arithmetic shift, with its output register. Parameters DATA_BITS and FADE_LOG2. The arbiter FSM instantiates it once, after a mux selected by grant.

Test Plan (FADE_LOG2=2, i.e. a 4-frame ramp, to shorten sims; lrclk from i2s_clkgen CLK_DIV=4):
1. req=3'b001, src0=24'sd4000 -> gain steps 1,2,3,4 on successive ticks; out_sample = 1000, 2000, 3000, 4000; then PLAY, busy=0, grant=001.
2. In PLAY on src1 (src1=-24'sd4000), assert req[0] -> out_sample = -3000, -2000, -1000, 0. Then grant=001 and out_sample = 1000 .. 4000.
3. Raise req[0] while in FADE_IN at gain=2 on src2 -> gain goes 2, 1, 0, then fades in src0; never exceeds 2 before the switch.
4. mute=1 in PLAY -> fades to 0, IDLE, grant=000. Release mute -> fades back in on the same source.
5. Negative rounding: src0=-24'sd3, gain=1 -> out_sample=-1 (floor). src0=24'sd3 -> 0.
6. Pulse rst_n low at gain=3 -> out_sample=0, grant=0, state=IDLE at once. After release with req held, the next tick starts FADE_IN at gain=1.
